// File: rtl/div_mod_seq_if.sv
// ============================================================================
// Module      : div_mod_seq_if
// Description : Start/ready/done handshake and result bus for div_mod_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_mod_seq_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output a, b, start,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  a, b, start,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/div_mod_seq.sv
// ============================================================================
// Module      : div_mod_seq
// Description : Sequential restoring unsigned divider, one quotient bit per
//               cycle; returns quotient and remainder of a / b.
//               Optional macro DIVMOD_ZERO_CHECK_EN: early exit and flag on b=0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_mod_seq #(
  parameter int WIDTH = 7
) (
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire logic      interboard_rst,
  div_mod_seq_if.slave   bus
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  // Dividend and quotient share one register: dividend bits leave at the MSB
  // while quotient bits enter at the LSB.
  logic [WIDTH-1:0]   r_dq;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;

  logic               w_rst;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_dq_next;

  assign w_rst = rst | interboard_rst;

  // The partial remainder is WIDTH+1 bits wide only during the compare; after
  // a restoring step it is always below the divisor and fits in WIDTH bits.
  assign w_shift    = {r_rem, r_dq[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_rem_next = w_ge ? WIDTH'(w_shift - {1'b0, r_divisor}) : w_shift[WIDTH-1:0];
  assign w_dq_next  = {r_dq[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
`ifdef DIVMOD_ZERO_CHECK_EN
          w_next = (bus.b == '0) ? S_FIN : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (r_cnt == c_CNT_W'(1)) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef DIVMOD_ZERO_CHECK_EN
  logic r_dbz;
`endif

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_dq        <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef DIVMOD_ZERO_CHECK_EN
      r_dbz       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dq      <= bus.a;
            r_divisor <= bus.b;
            r_rem     <= '0;
            r_cnt     <= c_CNT_W'(WIDTH);
`ifdef DIVMOD_ZERO_CHECK_EN
            if (bus.b == '0) begin
              r_quotient  <= '1;
              r_remainder <= bus.a;
              r_dbz       <= 1'b1;
            end
`endif
          end
        end
        S_CALC: begin
          r_dq  <= w_dq_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - c_CNT_W'(1);
          // Results are published only on the final step, i.e. on entry to FIN.
          if (r_cnt == c_CNT_W'(1)) begin
            r_quotient  <= w_dq_next;
            r_remainder <= w_rem_next;
`ifdef DIVMOD_ZERO_CHECK_EN
            r_dbz       <= 1'b0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
`ifdef DIVMOD_ZERO_CHECK_EN
  assign bus.div_by_zero = r_dbz;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_mod_seq.sv
// ============================================================================
// Module      : tb_div_mod_seq
// Description : Self-checking bench for div_mod_seq at WIDTH=7 and WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_mod_seq;

`ifdef DIVMOD_ZERO_CHECK_EN
  localparam bit c_ZC = 1'b1;
`else
  localparam bit c_ZC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ib_rst7 = 1'b0;
  logic ib_rst16 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  div_mod_seq_if #(.WIDTH(7))  bus7 ();
  div_mod_seq_if #(.WIDTH(16)) bus16 ();

  div_mod_seq #(.WIDTH(7)) dut7 (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (ib_rst7),
    .bus            (bus7.slave)
  );

  div_mod_seq #(.WIDTH(16)) dut16 (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (ib_rst16),
    .bus            (bus16.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic; b=0 gives all-ones quotient and remainder a.
  task automatic expect_res(input string tag, input int w, input logic [31:0] av,
                            input logic [31:0] bv, input int lat,
                            input logic [31:0] q, input logic [31:0] r, input logic z);
    logic [31:0] eq, er;
    int          elat;
    eq   = (bv == 0) ? ((32'd1 << w) - 1) : av / bv;
    er   = (bv == 0) ? av : av % bv;
    elat = (bv == 0 && c_ZC) ? 0 : w;
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_quo"}, q, eq);
    chk({tag, "_rem"}, r, er);
    chk({tag, "_dbz"}, {31'd0, z}, {31'd0, (bv == 0) && c_ZC});
  endtask

  // Launch one operation; lat counts edges after the accepting edge until done.
  task automatic run7(input string tag, input logic [6:0] av, input logic [6:0] bv);
    int lat;
    chk({tag, "_rdy"}, {31'd0, bus7.ready}, 32'd1);
    bus7.a = av; bus7.b = bv; bus7.start = 1'b1;
    tick();
    bus7.start = 1'b0;
    bus7.a = 7'($urandom); bus7.b = 7'($urandom);
    lat = 0;
    while (bus7.done !== 1'b1 && lat < 200) begin tick(); lat++; end
    expect_res(tag, 7, {25'd0, av}, {25'd0, bv}, lat,
               {25'd0, bus7.quotient}, {25'd0, bus7.remainder}, bus7.div_by_zero);
    tick();
    chk({tag, "_done1"}, {31'd0, bus7.done}, 32'd0);
    chk({tag, "_rdy2"}, {31'd0, bus7.ready}, 32'd1);
  endtask

  task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv);
    int lat;
    bus16.a = av; bus16.b = bv; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    lat = 0;
    while (bus16.done !== 1'b1 && lat < 200) begin tick(); lat++; end
    expect_res(tag, 16, {16'd0, av}, {16'd0, bv}, lat,
               {16'd0, bus16.quotient}, {16'd0, bus16.remainder}, bus16.div_by_zero);
    tick();
    chk({tag, "_done1"}, {31'd0, bus16.done}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          pulses;
    logic [6:0]  ra, rb;
    logic [15:0] hq, hr;

    bus7.a = '0;  bus7.b = '0;  bus7.start = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.start = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, bus7.ready}, 32'd1);
    chk("rst_done",  {31'd0, bus7.done}, 32'd0);
    chk("rst_quo",   {25'd0, bus7.quotient}, 32'd0);
    chk("rst_rem",   {25'd0, bus7.remainder}, 32'd0);
    chk("rst_dbz",   {31'd0, bus7.div_by_zero}, 32'd0);
    chk("rst_ready16", {31'd0, bus16.ready}, 32'd1);

    // Directed cases and boundaries
    run7("d100_7", 7'd100, 7'd7);
    run7("lt", 7'd5, 7'd9);
    run7("b1", 7'd127, 7'd1);
    run7("a0", 7'd0, 7'd3);
    run7("aeqb", 7'd127, 7'd127);
    run7("max2", 7'd127, 7'd2);
    run7("bz", 7'd45, 7'd0);

    // Start held high; a changes during CALC
    bus7.a = 7'd50; bus7.b = 7'd6; bus7.start = 1'b1;
    tick();
    bus7.a = 7'd1;
    chk("hold_busy", {31'd0, bus7.ready}, 32'd0);
    lat = 0;
    while (bus7.done !== 1'b1 && lat < 200) begin tick(); lat++; end
    expect_res("hold1", 7, 32'd50, 32'd6, lat,
               {25'd0, bus7.quotient}, {25'd0, bus7.remainder}, bus7.div_by_zero);
    tick();
    chk("hold_idle_rdy", {31'd0, bus7.ready}, 32'd1);
    chk("hold_idle_done", {31'd0, bus7.done}, 32'd0);
    tick();
    chk("hold_reaccept", {31'd0, bus7.ready}, 32'd0);
    bus7.start = 1'b0;
    lat = 0;
    while (bus7.done !== 1'b1 && lat < 200) begin tick(); lat++; end
    expect_res("hold2", 7, 32'd1, 32'd6, lat,
               {25'd0, bus7.quotient}, {25'd0, bus7.remainder}, bus7.div_by_zero);
    tick();

    // Interboard reset three cycles into CALC
    bus7.a = 7'd100; bus7.b = 7'd7; bus7.start = 1'b1;
    tick();
    bus7.start = 1'b0;
    tick(); tick();
    ib_rst7 = 1'b1;
    tick();
    ib_rst7 = 1'b0;
    chk("ibr_ready", {31'd0, bus7.ready}, 32'd1);
    chk("ibr_done",  {31'd0, bus7.done}, 32'd0);
    chk("ibr_quo",   {25'd0, bus7.quotient}, 32'd0);
    chk("ibr_rem",   {25'd0, bus7.remainder}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus7.done === 1'b1) pulses++;
      tick();
    end
    chk("ibr_nodone", pulses, 0);
    run7("ibr_again", 7'd100, 7'd7);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      ra = 7'($urandom);
      rb = (i % 7 == 0) ? 7'd0 : 7'($urandom);
      run7("rnd", ra, rb);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    // WIDTH=16 and result hold through IDLE
    run16("w16", 16'd60000, 16'd255);
    hq = bus16.quotient; hr = bus16.remainder;
    for (int i = 0; i < 5; i++) begin
      bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      tick();
    end
    chk("w16_holdq", {16'd0, bus16.quotient}, 32'd235);
    chk("w16_holdr", {16'd0, bus16.remainder}, 32'd75);
    chk("w16_holdq_same", {16'd0, bus16.quotient}, {16'd0, hq});
    chk("w16_holdr_same", {16'd0, bus16.remainder}, {16'd0, hr});
    for (int i = 0; i < 8; i++) begin
      run16("w16rnd", 16'($urandom), (i == 3) ? 16'd0 : 16'($urandom_range(1, 65535)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
